// File: rtl/nn_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_host_pkg
// Description : Shared types for the CNN host sequencer: FSM state encoding,
//               argument-word bit positions and the result FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_host_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CFG   = 3'd1,
    ST_START = 3'd2,
    ST_CLR   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_PUSH  = 3'd5
  } state_e;

  // Bit positions inside the 32-bit nn_arg word
  localparam int ARG_WE     = 0;
  localparam int ARG_START  = 1;
  localparam int ARG_RESIZE = 2;
  localparam int ARG_BIN    = 3;

  // Result queue entry: err marks a watchdog give-up, data is the prediction
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } res_entry_t;

  localparam int ENTRY_W = $bits(res_entry_t);

  // Build the argument word; all bits above ARG_BIN stay zero
  function automatic logic [31:0] make_arg(input logic bin, input logic resize,
                                           input logic start, input logic we);
    logic [31:0] arg;
    arg             = '0;
    arg[ARG_WE]     = we;
    arg[ARG_START]  = start;
    arg[ARG_RESIZE] = resize;
    arg[ARG_BIN]    = bin;
    return arg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_host_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nn_host_ctrl_if
// Description : Host command, CNN handshake and result-queue signals of the
//               CNN host sequencer. The slave modport is the sequencer, the
//               master modport is the bus glue / NN wrapper side.
// Revision    : 1.0 - initial release
// ============================================================================
interface nn_host_ctrl_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_resized;
  logic        cmd_bin;
  logic        cmd_cont;
  logic        stop;
  logic [31:0] nn_arg;
  logic [31:0] nn_data;
  logic        nn_en;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_resized, cmd_bin, cmd_cont, stop,
    input  nn_data, nn_en, res_ready,
    output cmd_ready, nn_arg, res_data, res_err, res_valid, busy
  );

  modport master (
    output cmd_valid, cmd_resized, cmd_bin, cmd_cont, stop,
    output nn_data, nn_en, res_ready,
    input  cmd_ready, nn_arg, res_data, res_err, res_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/nn_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nn_result_fifo
// Description : Synchronous FIFO for CNN results. Pointers carry one extra
//               wrap bit; push while full is accepted only together with a
//               pop. Pop while empty is ignored. DEPTH: power of 2, >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Head is forced to zero when empty so the outputs read 0 after reset
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Storage write; contents are don't-care until pointed at
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Read/write pointer advance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nn_host_ctrl
// Description : Host-side sequencer for the CNN nn_arg/nn_data/nn_en
//               handshake. Issues WE/start pulses with resize and binarize
//               switches, waits for the result pulse and queues results for
//               the CPU side. Optional watchdog with retry is compiled in
//               with the macro NN_HOST_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_host_ctrl
  import nn_host_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 2**20,
  parameter int MAX_RETRY  = 3
) (
  input  logic           CLK,
  input  logic           RST,
  nn_host_ctrl_if.slave  bus
);

  state_e      state_q;
  logic [31:0] nn_arg_q;
  logic        busy_q;
  logic        resize_q;
  logic        bin_q;
  logic        cont_q;
  logic        stop_seen_q;
  res_entry_t  hold_q;
  res_entry_t  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_can_push;

`ifdef NN_HOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] retry_q;
  logic          timeout_hit;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

  // Push happens from PUSH whenever a slot is free or being freed this cycle
  assign fifo_push     = (state_q == ST_PUSH);
  assign fifo_can_push = !fifo_full || (bus.res_ready && !fifo_empty);

  nn_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .wdata_i (hold_q),
    .pop_i   (bus.res_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = busy_q;
  assign bus.nn_arg    = nn_arg_q;
  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = head.data;

`ifdef NN_HOST_TIMEOUT_EN
  assign bus.res_err   = head.err;
`else
  // Without the watchdog no error entry can exist; parameters are inert
  logic unused_cfg;
  assign unused_cfg  = head.err ^ (TIMEOUT > 0) ^ (MAX_RETRY > 0);
  assign bus.res_err = 1'b0;
`endif

  // Sequencer FSM; nn_arg and busy are registered alongside the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      nn_arg_q    <= '0;
      busy_q      <= 1'b0;
      resize_q    <= 1'b0;
      bin_q       <= 1'b0;
      cont_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      hold_q      <= '0;
`ifdef NN_HOST_TIMEOUT_EN
      retry_q     <= '0;
`endif
    end else begin
      if ((state_q != ST_IDLE) && bus.stop) begin
        stop_seen_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            resize_q    <= bus.cmd_resized;
            bin_q       <= bus.cmd_bin;
            cont_q      <= bus.cmd_cont;
            stop_seen_q <= 1'b0;
`ifdef NN_HOST_TIMEOUT_EN
            retry_q     <= '0;
`endif
            busy_q      <= 1'b1;
            nn_arg_q    <= make_arg(bus.cmd_bin, bus.cmd_resized, 1'b0, 1'b1);
            state_q     <= ST_CFG;
          end
        end
        ST_CFG: begin
          nn_arg_q <= make_arg(bin_q, resize_q, 1'b1, 1'b1);
          state_q  <= ST_START;
        end
        ST_START: begin
          // Drop start right away so the wrapper never sees it held
          nn_arg_q <= make_arg(bin_q, resize_q, 1'b0, 1'b1);
          state_q  <= ST_CLR;
        end
        ST_CLR: begin
          nn_arg_q <= make_arg(bin_q, resize_q, 1'b0, 1'b0);
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the timeout cycle takes priority over retry
          if (bus.nn_en) begin
            hold_q  <= '{err: 1'b0, data: bus.nn_data};
            state_q <= ST_PUSH;
          end
`ifdef NN_HOST_TIMEOUT_EN
          else if (timeout_hit) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q  <= retry_q + 1'b1;
              nn_arg_q <= make_arg(bin_q, resize_q, 1'b1, 1'b1);
              state_q  <= ST_START;
            end else begin
              hold_q  <= '{err: 1'b1, data: 32'd0};
              state_q <= ST_PUSH;
            end
          end
`endif
        end
        ST_PUSH: begin
          // Stall with hold_q stable until the queue can take the entry
          if (fifo_can_push) begin
            if (cont_q && !(stop_seen_q || bus.stop)) begin
              nn_arg_q <= make_arg(bin_q, resize_q, 1'b0, 1'b1);
              state_q  <= ST_CFG;
            end else begin
              nn_arg_q <= '0;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
        end
        default: begin
          nn_arg_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NN_HOST_TIMEOUT_EN
  // Watchdog counts only while waiting; cleared in every other state
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if ((state_q == ST_WAIT) && !bus.nn_en && !timeout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`endif

endmodule
`default_nettype wire
